// File: rtl/run_monitor.sv
// Run-control monitor: counts RUN cycles and retirements, ends the run on halt,
// timeout or retire stall, then drains before reporting done.
module run_monitor #(
  parameter int unsigned CYCLE_W      = 32,
  parameter int unsigned MAX_CYCLES   = 49,
  parameter int unsigned STALL_LIMIT  = 16,
  parameter int unsigned DRAIN_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt_in,
  input  logic               retire_valid,
  output logic               complete,
  output logic               done,
  output logic [1:0]         status,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic [CYCLE_W-1:0] retired_count
);

  localparam int unsigned STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  // Terminal counter values; only consulted when the matching feature is enabled.
  localparam logic [CYCLE_W-1:0] MAX_LAST   = CYCLE_W'(MAX_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  if (CYCLE_W < 64) begin : g_max_check
    if (64'(MAX_CYCLES) >= (64'd1 << CYCLE_W)) begin : g_max_too_big
      $error("run_monitor: MAX_CYCLES does not fit in CYCLE_W bits");
    end
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    EXIT_NONE,
    EXIT_HALT,
    EXIT_TIMEOUT,
    EXIT_STALL
  } exit_e;

  state_e             state_q,    state_d;
  exit_e              status_q,   status_d;
  logic [CYCLE_W-1:0] cycle_q,    cycle_d;
  logic [CYCLE_W-1:0] retired_q,  retired_d;
  logic [STALL_W-1:0] stall_q,    stall_d;
  logic [DRAIN_W-1:0] drain_q,    drain_d;
  logic               complete_q, complete_d;
  logic               done_q,     done_d;

  logic halt_hit;
  logic timeout_hit;
  logic stall_hit;

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    cycle_d     = cycle_q;
    retired_d   = retired_q;
    stall_d     = stall_q;
    drain_d     = drain_q;
    halt_hit    = 1'b0;
    timeout_hit = 1'b0;
    stall_hit   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (cycle_q != '1) begin
          cycle_d = cycle_q + CYCLE_W'(1);
        end
        if (retire_valid && (retired_q != '1)) begin
          retired_d = retired_q + CYCLE_W'(1);
        end
        if (STALL_LIMIT != 0) begin
          stall_d = retire_valid ? '0 : stall_q + STALL_W'(1);
        end

        halt_hit    = halt_in;
        timeout_hit = (MAX_CYCLES != 0) && (cycle_q == MAX_LAST);
        stall_hit   = (STALL_LIMIT != 0) && !retire_valid && (stall_q == STALL_LAST);

        // The exit cycle is still counted above; only the state and reason change here.
        if (halt_hit || timeout_hit || stall_hit) begin
          if (halt_hit) begin
            status_d = EXIT_HALT;
          end else if (timeout_hit) begin
            status_d = EXIT_TIMEOUT;
          end else begin
            status_d = EXIT_STALL;
          end
          state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
          drain_d = '0;
        end
      end

      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    complete_d = (state_d == S_DRAIN) || (state_d == S_DONE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      status_q   <= EXIT_NONE;
      cycle_q    <= '0;
      retired_q  <= '0;
      stall_q    <= '0;
      drain_q    <= '0;
      complete_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      cycle_q    <= cycle_d;
      retired_q  <= retired_d;
      stall_q    <= stall_d;
      drain_q    <= drain_d;
      complete_q <= complete_d;
      done_q     <= done_d;
    end
  end

  assign complete      = complete_q;
  assign done          = done_q;
  assign status        = status_q;
  assign cycle_count   = cycle_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: per-cycle vector tables plus hand-written
// multi-cycle runs across five parameterisations.
module tb_run_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance map: 0 defaults, 1 STALL_LIMIT=4, 2 MAX=8/STALL=8, 3 DRAIN=0, 4 DRAIN=5
  logic [4:0]  rst_v, st_v, hl_v, rv_v;
  logic [4:0]  cmp_v, dn_v;
  logic [1:0]  stat_v [5];
  logic [31:0] cc_v   [5];
  logic [31:0] rc_v   [5];

  int n_checks = 0;
  int n_fail   = 0;

  run_monitor u0 (
    .clk(clk), .reset(rst_v[0]), .start(st_v[0]), .halt_in(hl_v[0]), .retire_valid(rv_v[0]),
    .complete(cmp_v[0]), .done(dn_v[0]), .status(stat_v[0]),
    .cycle_count(cc_v[0]), .retired_count(rc_v[0])
  );

  run_monitor #(.STALL_LIMIT(4)) u1 (
    .clk(clk), .reset(rst_v[1]), .start(st_v[1]), .halt_in(hl_v[1]), .retire_valid(rv_v[1]),
    .complete(cmp_v[1]), .done(dn_v[1]), .status(stat_v[1]),
    .cycle_count(cc_v[1]), .retired_count(rc_v[1])
  );

  run_monitor #(.MAX_CYCLES(8), .STALL_LIMIT(8)) u2 (
    .clk(clk), .reset(rst_v[2]), .start(st_v[2]), .halt_in(hl_v[2]), .retire_valid(rv_v[2]),
    .complete(cmp_v[2]), .done(dn_v[2]), .status(stat_v[2]),
    .cycle_count(cc_v[2]), .retired_count(rc_v[2])
  );

  run_monitor #(.DRAIN_CYCLES(0)) u3 (
    .clk(clk), .reset(rst_v[3]), .start(st_v[3]), .halt_in(hl_v[3]), .retire_valid(rv_v[3]),
    .complete(cmp_v[3]), .done(dn_v[3]), .status(stat_v[3]),
    .cycle_count(cc_v[3]), .retired_count(rc_v[3])
  );

  run_monitor #(.DRAIN_CYCLES(5)) u4 (
    .clk(clk), .reset(rst_v[4]), .start(st_v[4]), .halt_in(hl_v[4]), .retire_valid(rv_v[4]),
    .complete(cmp_v[4]), .done(dn_v[4]), .status(stat_v[4]),
    .cycle_count(cc_v[4]), .retired_count(rc_v[4])
  );

  typedef struct {
    int idx;
    bit rst;
    bit st;
    bit hl;
    bit rv;
    bit c;
    bit d;
    int s;
    int cc;
    int rc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int idx, input bit rst, input bit st, input bit hl,
                              input bit rv, input bit c, input bit d, input int s,
                              input int cc, input int rc);
    vecs.push_back('{idx, rst, st, hl, rv, c, d, s, cc, rc});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_outs(input int i, input bit c, input bit d, input int s,
                            input int cc, input int rc, input string tag);
    chk({tag, ".complete"},      64'(cmp_v[i]), 64'(c));
    chk({tag, ".done"},          64'(dn_v[i]),  64'(d));
    chk({tag, ".status"},        64'(stat_v[i]), 64'(s));
    chk({tag, ".cycle_count"},   64'(cc_v[i]),  64'(cc));
    chk({tag, ".retired_count"}, 64'(rc_v[i]),  64'(rc));
  endtask

  task automatic run_to_complete(input int i, input int limit, output int n);
    n = 0;
    while (!cmp_v[i] && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic count_to_done(input int i, input int limit, output int n);
    n = 0;
    while (!dn_v[i] && n < limit) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_v = '1;
    st_v  = '0;
    hl_v  = '0;
    rv_v  = '0;

    // Stall exit with STALL_LIMIT=4: 5 retires, then 4 idle cycles.
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) add(1, 0, 0, 0, 1, 0, 0, 0, k, k);
    for (int k = 6; k <= 8; k++) add(1, 0, 0, 0, 0, 0, 0, 0, k, 5);
    add(1, 0, 0, 0, 0, 1, 0, 3, 9, 5);
    add(1, 0, 1, 1, 1, 1, 1, 3, 9, 5);
    add(1, 0, 1, 1, 1, 1, 1, 3, 9, 5);

    // Halt, timeout and stall coincide on cycle 8: halt wins; then timeout beats stall.
    add(2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 7; k++) add(2, 0, 0, 0, 0, 0, 0, 0, k, 0);
    add(2, 0, 0, 1, 0, 1, 0, 1, 8, 0);
    add(2, 0, 0, 0, 0, 1, 1, 1, 8, 0);
    add(2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 7; k++) add(2, 0, 0, 0, 0, 0, 0, 0, k, 0);
    add(2, 0, 0, 0, 0, 1, 0, 2, 8, 0);
    add(2, 0, 0, 0, 0, 1, 1, 2, 8, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_v[vecs[i].idx] = vecs[i].rst;
      st_v[vecs[i].idx]  = vecs[i].st;
      hl_v[vecs[i].idx]  = vecs[i].hl;
      rv_v[vecs[i].idx]  = vecs[i].rv;
      step();
      check_outs(vecs[i].idx, vecs[i].c, vecs[i].d, vecs[i].s, vecs[i].cc, vecs[i].rc,
                 $sformatf("vec%0d", i));
    end

    // Defaults: timeout run with retire every cycle.
    rv_v[0] = 1'b1;
    check_outs(0, 0, 0, 0, 0, 0, "A.reset");
    rst_v[0] = 1'b0;
    st_v[0]  = 1'b1;
    step();
    chk("A.start_cc", 64'(cc_v[0]), 64'd0);
    st_v[0] = 1'b0;
    run_to_complete(0, 60, n);
    chk("A.latency", 64'(n), 64'd49);
    check_outs(0, 1, 0, 2, 49, 49, "A.exit");
    step();
    check_outs(0, 1, 1, 2, 49, 49, "A.done");

    // Defaults: halt with retire on RUN cycle 10.
    rst_v[0] = 1'b1;
    step();
    step();
    rst_v[0] = 1'b0;
    st_v[0]  = 1'b1;
    step();
    st_v[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      hl_v[0] = (k == 10);
      step();
      if (k == 9) check_outs(0, 0, 0, 0, 9, 9, "B.pre_halt");
    end
    hl_v[0] = 1'b0;
    check_outs(0, 1, 0, 1, 10, 10, "B.exit");
    step();
    check_outs(0, 1, 1, 1, 10, 10, "B.done");

    // DRAIN_CYCLES=0: complete and done rise together.
    rv_v[3] = 1'b1;
    check_outs(3, 0, 0, 0, 0, 0, "C.reset");
    rst_v[3] = 1'b0;
    st_v[3]  = 1'b1;
    step();
    st_v[3] = 1'b0;
    run_to_complete(3, 60, n);
    chk("C.latency", 64'(n), 64'd49);
    check_outs(3, 1, 1, 2, 49, 49, "C.exit");

    // DRAIN_CYCLES=5: done trails complete by 5 cycles.
    rv_v[4]  = 1'b1;
    rst_v[4] = 1'b0;
    st_v[4]  = 1'b1;
    step();
    st_v[4] = 1'b0;
    run_to_complete(4, 60, n);
    chk("D.latency", 64'(n), 64'd49);
    check_outs(4, 1, 0, 2, 49, 49, "D.exit");
    count_to_done(4, 10, n);
    chk("D.drain_len", 64'(n), 64'd5);

    // Reset two cycles into DRAIN, then an identical fresh run.
    rst_v[4] = 1'b1;
    step();
    rst_v[4] = 1'b0;
    st_v[4]  = 1'b1;
    step();
    st_v[4] = 1'b0;
    run_to_complete(4, 60, n);
    step();
    check_outs(4, 1, 0, 2, 49, 49, "E.in_drain");
    rst_v[4] = 1'b1;
    step();
    check_outs(4, 0, 0, 0, 0, 0, "E.reset_in_drain");
    rst_v[4] = 1'b0;
    st_v[4]  = 1'b1;
    step();
    chk("E.start_cc", 64'(cc_v[4]), 64'd0);
    st_v[4] = 1'b0;
    run_to_complete(4, 60, n);
    chk("E.latency", 64'(n), 64'd49);
    check_outs(4, 1, 0, 2, 49, 49, "E.exit");
    count_to_done(4, 10, n);
    chk("E.drain_len", 64'(n), 64'd5);
    check_outs(4, 1, 1, 2, 49, 49, "E.done");

    // start/halt while in DONE leave everything unchanged.
    st_v[4] = 1'b1;
    hl_v[4] = 1'b1;
    step();
    st_v[4] = 1'b0;
    hl_v[4] = 1'b0;
    check_outs(4, 1, 1, 2, 49, 49, "F.start_in_done");
    step();
    check_outs(4, 1, 1, 2, 49, 49, "F.sticky");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
